// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: bus widths, funct3 codes, LSU state
// encoding and small decode helpers.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned BYTE_SIZE = 8;
    localparam int unsigned MEM_STEPS = 4;
    localparam int unsigned WORD_W    = XLEN - 2;
    localparam int unsigned WIN_W     = 2 * XLEN;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef logic [MEM_STEPS-1:0][BYTE_SIZE-1:0] mem_word_t;

    // Stores only have SB/SH/SW; loads additionally allow LBU/LHU.
    function automatic logic f3_illegal(input logic store, input logic [2:0] funct3);
        if (store) begin
            return funct3[2] || (funct3[1:0] == 2'b11);
        end
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

    // Access size in bytes from the width bits of funct3.
    function automatic logic [2:0] f3_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU: places store bytes into an 8-byte two-beat
// window and extracts/extends load bytes from the same window.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    input  mem_word_t       beat0,
    input  mem_word_t       beat1,
    output logic            split_c,
    output logic [3:0]      be0_c,
    output logic [3:0]      be1_c,
    output logic [XLEN-1:0] wd0_c,
    output logic [XLEN-1:0] wd1_c,
    output logic [XLEN-1:0] rdata_c
);

    logic [2:0]       size;
    logic [4:0]       sh;
    logic [7:0]       size_mask;
    logic [7:0]       win_mask;
    logic [XLEN-1:0]  data_mask;
    logic [WIN_W-1:0] win_data;
    logic [XLEN-1:0]  raw;

    // Store direction: shift masked data and lane mask by the byte offset.
    always_comb begin
        size      = f3_size(funct3);
        sh        = {offset, 3'b000};
        size_mask = 8'h0F;
        data_mask = '1;
        case (size)
            3'd1: begin
                size_mask = 8'h01;
                data_mask = XLEN'(32'h0000_00FF);
            end
            3'd2: begin
                size_mask = 8'h03;
                data_mask = XLEN'(32'h0000_FFFF);
            end
            default: ;
        endcase
        win_mask = 8'(size_mask << offset);
        win_data = WIN_W'(wdata & data_mask) << sh;
        split_c  = (3'({1'b0, offset}) + size) > 3'd4;
        be0_c    = win_mask[3:0];
        be1_c    = win_mask[7:4];
        wd0_c    = win_data[XLEN-1:0];
        wd1_c    = win_data[WIN_W-1:XLEN];
    end

    // Load direction: pull the access down to bit 0, then extend.
    always_comb begin
        raw = XLEN'({beat1, beat0} >> sh);
        case (funct3)
            F3_B:    rdata_c = {{(XLEN-8){raw[7]}}, raw[7:0]};
            F3_BU:   rdata_c = {{(XLEN-8){1'b0}}, raw[7:0]};
            F3_H:    rdata_c = {{(XLEN-16){raw[15]}}, raw[15:0]};
            F3_HU:   rdata_c = {{(XLEN-16){1'b0}}, raw[15:0]};
            default: rdata_c = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator: one request at a time, split into up to
// two word beats, with a registered one-cycle response.
module load_store_unit
    import riscv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [2:0]           req_funct3,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [4:0]           req_rd,
    output logic                 rsp_valid,
    output logic [XLEN-1:0]      rsp_rdata,
    output logic [4:0]           rsp_rd,
    output logic                 rsp_error,
    output logic                 mem_read_enable,
    output logic                 mem_write_enable,
    output logic [XLEN-1:0]      mem_addr,
    output logic [MEM_STEPS-1:0] mem_byte_en,
    output mem_word_t            mem_write_data,
    input  mem_word_t            mem_read_data
);

    lsu_state_t      state;
    logic            cur_store;
    logic [2:0]      cur_f3;
    logic [XLEN-1:0] cur_addr;
    logic [XLEN-1:0] cur_wdata;
    logic [4:0]      cur_rd;
    logic            cur_err;
    logic            cur_split;
    mem_word_t       beat0_q;

    logic            op_store;
    logic [2:0]      op_f3;
    logic [XLEN-1:0] op_addr;
    logic [XLEN-1:0] op_wdata;
    logic            illegal_c;
    mem_word_t       ld_beat0;
    logic            split_c;
    logic [3:0]      be0_c;
    logic [3:0]      be1_c;
    logic [XLEN-1:0] wd0_c;
    logic [XLEN-1:0] wd1_c;
    logic [XLEN-1:0] rdata_c;

    // In IDLE the beat-0 strobes are prepared straight from the request.
    always_comb begin
        op_store  = (state == IDLE) ? req_store  : cur_store;
        op_f3     = (state == IDLE) ? req_funct3 : cur_f3;
        op_addr   = (state == IDLE) ? req_addr   : cur_addr;
        op_wdata  = (state == IDLE) ? req_wdata  : cur_wdata;
        illegal_c = f3_illegal(op_store, op_f3);
        ld_beat0  = cur_split ? beat0_q : mem_read_data;
    end

    lsu_align u_align (
        .offset  (op_addr[1:0]),
        .funct3  (op_f3),
        .wdata   (op_wdata),
        .beat0   (ld_beat0),
        .beat1   (mem_read_data),
        .split_c (split_c),
        .be0_c   (be0_c),
        .be1_c   (be1_c),
        .wd0_c   (wd0_c),
        .wd1_c   (wd1_c),
        .rdata_c (rdata_c)
    );

    // FSM, request latch, registered memory strobes and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            req_ready        <= 1'b1;
            cur_store        <= 1'b0;
            cur_f3           <= 3'd0;
            cur_addr         <= '0;
            cur_wdata        <= '0;
            cur_rd           <= 5'd0;
            cur_err          <= 1'b0;
            cur_split        <= 1'b0;
            beat0_q          <= '0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
            rsp_rd           <= 5'd0;
            rsp_error        <= 1'b0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_addr         <= '0;
            mem_byte_en      <= '0;
            mem_write_data   <= '0;
        end else begin
            rsp_valid        <= 1'b0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_addr         <= '0;
            mem_byte_en      <= '0;
            mem_write_data   <= '0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        cur_store <= req_store;
                        cur_f3    <= req_funct3;
                        cur_addr  <= req_addr;
                        cur_wdata <= req_wdata;
                        cur_rd    <= req_rd;
                        cur_err   <= illegal_c;
                        cur_split <= split_c && !illegal_c;
                        req_ready <= 1'b0;
                        state     <= LO;
                        if (!illegal_c) begin
                            mem_read_enable  <= !req_store;
                            mem_write_enable <= req_store;
                            mem_addr         <= XLEN'(req_addr[XLEN-1:2]);
                            if (req_store) begin
                                mem_byte_en    <= be0_c;
                                mem_write_data <= wd0_c;
                            end
                        end
                    end
                end
                LO: begin
                    if (cur_split) begin
                        state            <= HI;
                        mem_read_enable  <= !cur_store;
                        mem_write_enable <= cur_store;
                        mem_addr         <= XLEN'(WORD_W'(cur_addr[XLEN-1:2] + WORD_W'(1)));
                        if (cur_store) begin
                            mem_byte_en    <= be1_c;
                            mem_write_data <= wd1_c;
                        end
                    end else begin
                        state <= DONE;
                    end
                end
                HI: begin
                    beat0_q <= mem_read_data;
                    state   <= DONE;
                end
                DONE: begin
                    rsp_valid <= 1'b1;
                    rsp_rd    <= cur_rd;
                    rsp_error <= cur_err;
                    rsp_rdata <= (cur_store || cur_err) ? '0 : rdata_c;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
